// File: rtl/mmio_uart_tx_if.sv
// Data-bus port shared with data RAM: store strobe, byte address, write/read data and select.
// The processor side is the master; the UART register window is the slave.
interface mmio_uart_tx_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;

    modport master (output we, addr, wdata, input rdata, sel);
    modport slave  (input we, addr, wdata, output rdata, sel);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window, TX FIFO, programmable baud divisor.
// Reads are combinational and never change state.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic            clk,
    input  logic            reset,
    mmio_uart_tx_if.slave   bus,
    output logic            tx
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   bauddiv;
    logic [15:0]   div_q;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    logic          hit, full, empty, busy, baud_end;
    logic          push_req, do_push, pop;
    logic [1:0]    idx;
    logic          unused;

    assign hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign idx      = bus.addr[3:2];
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign baud_end = (baud_cnt == div_q - 16'd1);
    assign push_req = bus.we && hit && (idx == 2'd0);
    assign do_push  = push_req && !full;
    // Pops happen only when the FSM loads a new frame: from IDLE, or at the very end of STOP.
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baud_end));
    assign unused   = ^{bus.addr[1:0], bus.wdata[31:16]};

    assign bus.sel = hit;

    always_comb begin
        bus.rdata = '0;
        if (hit) begin
            case (idx)
                2'd1:    bus.rdata = {28'b0, overflow, busy, empty, full};
                2'd2:    bus.rdata = {16'b0, bauddiv};
                2'd3:    bus.rdata = 32'(count);
                default: bus.rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem[wr_ptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            bauddiv  <= DEFAULT_DIV;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full)
                overflow <= 1'b1;
            else if (bus.we && hit && (idx == 2'd1) && bus.wdata[3])
                overflow <= 1'b0;
            if (bus.we && hit && (idx == 2'd2))
                bauddiv <= bus.wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            div_q    <= 16'd1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE, STOP: begin
                    if (state == IDLE || baud_end) begin
                        if (pop) begin
                            shift    <= mem[rd_ptr];
                            div_q    <= (bauddiv == '0) ? 16'd1 : bauddiv;
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= START;
                            tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx: register map, frame timing, FIFO overflow,
// divisor-zero handling, mid-frame reset and address decode misses.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx;
    int   checks = 0;
    int   fails  = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    // Drive a store for exactly one rising edge; returns at the negedge after that edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1 d = bus.rdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_read(BASE + 32'h4, d); checks++;
        if (d !== 32'h2) begin fails++; $display("FAIL reset_status got %h exp %h", d, 32'h2); end
        checks++;
        if (bus.sel !== 1'b1) begin fails++; $display("FAIL reset_sel_hit got %b exp 1", bus.sel); end
        bus_read(BASE + 32'h8, d); checks++;
        if (d !== 32'h10) begin fails++; $display("FAIL reset_bauddiv got %h exp %h", d, 32'h10); end
        bus_read(BASE + 32'hA, d); checks++;
        if (d !== 32'h10) begin fails++; $display("FAIL bauddiv_low_bits_ignored got %h exp %h", d, 32'h10); end
        bus_read(BASE + 32'hC, d); checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_count got %h exp 0", d); end
        bus_read(BASE, d); checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL txdata_read got %h exp 0", d); end
        checks++;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b exp 1", tx); end
        bus_read(32'h0000_1000, d); checks++;
        if (d !== 32'h0 || bus.sel !== 1'b0) begin
            fails++; $display("FAIL miss_read got rdata=%h sel=%b exp 0/0", d, bus.sel);
        end
    endtask

    task automatic test_frame;
        logic [31:0] d;
        logic [7:0]  b = 8'h55;
        logic        exp;
        bus_write(BASE + 32'h8, 32'd4);
        bus_write(BASE, 32'h0000_0155);
        checks++;
        if (tx !== 1'b1) begin fails++; $display("FAIL frame_latency_k0 got %b exp 1", tx); end
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            if (k <= 4)       exp = 1'b0;
            else if (k <= 36) exp = b[(k - 5) / 4];
            else              exp = 1'b1;
            checks++;
            if (tx !== exp) begin fails++; $display("FAIL frame_tx k=%0d got %b exp %b", k, tx, exp); end
            if (k == 20) begin
                bus_read(BASE + 32'h4, d); checks++;
                if (d !== 32'h6) begin fails++; $display("FAIL frame_status_busy got %h exp 6", d); end
            end
            if (k == 41) begin
                bus_read(BASE + 32'h4, d); checks++;
                if (d !== 32'h2) begin fails++; $display("FAIL frame_status_done got %h exp 2", d); end
            end
        end
    endtask

    task automatic test_overflow_back_to_back;
        logic [31:0] d;
        logic [7:0]  b;
        logic        exp;
        int          f, p, bp;
        @(negedge clk);
        bus.we = 1'b1; bus.addr = BASE; bus.wdata = 32'h10;
        for (int c = 0; c <= 370; c++) begin
            @(negedge clk);
            if (c < 1) exp = 1'b1;
            else begin
                f = (c - 1) / 40; p = (c - 1) % 40; bp = p / 4;
                b = 8'(8'h10 + f);
                if (f >= 9)       exp = 1'b1;
                else if (bp == 0) exp = 1'b0;
                else if (bp == 9) exp = 1'b1;
                else              exp = b[bp - 1];
            end
            checks++;
            if (tx !== exp) begin fails++; $display("FAIL b2b_tx c=%0d got %b exp %b", c, tx, exp); end
            if (c < 9) bus.wdata = 32'(8'h10 + c + 1);
            else if (c == 9) begin
                bus.we = 1'b0;
                bus_read(BASE + 32'h4, d); checks++;
                if (d !== 32'hD) begin fails++; $display("FAIL ovf_status got %h exp D", d); end
                bus_read(BASE + 32'hC, d); checks++;
                if (d !== 32'h8) begin fails++; $display("FAIL ovf_count got %h exp 8", d); end
                bus.we = 1'b1; bus.addr = BASE + 32'h4; bus.wdata = 32'h8;
            end else if (c == 10) begin
                bus.we = 1'b0;
                bus_read(BASE + 32'h4, d); checks++;
                if (d !== 32'h5) begin fails++; $display("FAIL ovf_clear_status got %h exp 5", d); end
            end
        end
    endtask

    task automatic test_div_zero;
        logic [9:0] pat = 10'b1101001010;
        logic       exp;
        bus_write(BASE + 32'h8, 32'd0);
        bus_write(BASE, 32'hA5);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k <= 10) ? pat[k - 1] : 1'b1;
            checks++;
            if (tx !== exp) begin fails++; $display("FAIL div0_tx k=%0d got %b exp %b", k, tx, exp); end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        bus_write(BASE + 32'h8, 32'd4);
        bus_write(BASE, 32'h01);
        repeat (10) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin fails++; $display("FAIL midframe_bit1 got %b exp 0", tx); end
        reset = 1'b1;
        bus.we = 1'b1; bus.addr = BASE + 32'h8; bus.wdata = 32'd8;
        @(negedge clk);
        reset = 1'b0; bus.we = 1'b0;
        checks++;
        if (tx !== 1'b1) begin fails++; $display("FAIL midreset_tx got %b exp 1", tx); end
        bus_read(BASE + 32'hC, d); checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL midreset_count got %h exp 0", d); end
        bus_read(BASE + 32'h8, d); checks++;
        if (d !== 32'h10) begin fails++; $display("FAIL midreset_bauddiv got %h exp 10", d); end
        bus_read(BASE + 32'h4, d); checks++;
        if (d !== 32'h2) begin fails++; $display("FAIL midreset_status got %h exp 2", d); end
        @(negedge clk); checks++;
        if (tx !== 1'b1) begin fails++; $display("FAIL midreset_tx_hold got %b exp 1", tx); end
    endtask

    task automatic test_decode_miss;
        logic [31:0] d;
        bus_write(BASE + 32'h10, 32'h41);
        bus_write(BASE + 32'h18, 32'd3);
        bus_read(BASE + 32'hC, d); checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL miss_write_count got %h exp 0", d); end
        bus_read(BASE + 32'h8, d); checks++;
        if (d !== 32'h10) begin fails++; $display("FAIL miss_write_bauddiv got %h exp 10", d); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus_read(BASE + 32'h4, d); checks++;
            if (d !== 32'h2) begin fails++; $display("FAIL idle_status i=%0d got %h exp 2", i, d); end
            bus_read(BASE + 32'hC, d); checks++;
            if (d !== 32'h0) begin fails++; $display("FAIL idle_count i=%0d got %h exp 0", i, d); end
            checks++;
            if (tx !== 1'b1) begin fails++; $display("FAIL idle_tx i=%0d got %b exp 1", i, tx); end
        end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_overflow_back_to_back;
        test_div_zero;
        test_reset_mid_frame;
        test_decode_miss;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
